// File: rtl/manual_drive_pkg.sv
// -----------------------------------------------------------------------------
// manual_drive_pkg
// Shared definitions for the manual-drive command path:
//   - state_t      : FSM states of manual_drive_ctrl
//   - DIR_*        : bit index of each direction in the 8-bit one-hot vector
//   - KEY_*        : bit position of each key in the command byte
// Optional feature macro: MANUAL_DRIVE_WATCHDOG_EN (adds the TIMEOUT state).
// -----------------------------------------------------------------------------
package manual_drive_pkg;

    localparam int DIR_W = 8;

    // One-hot direction bit positions
    localparam int DIR_F  = 0;
    localparam int DIR_B  = 1;
    localparam int DIR_L  = 2;
    localparam int DIR_R  = 3;
    localparam int DIR_LF = 4;
    localparam int DIR_RF = 5;
    localparam int DIR_LB = 6;
    localparam int DIR_RB = 7;

    // Key bit positions in the command byte
    localparam int KEY_W = 0;
    localparam int KEY_A = 1;
    localparam int KEY_S = 2;
    localparam int KEY_D = 3;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_STOP    = 2'd1,
`ifdef MANUAL_DRIVE_WATCHDOG_EN
        ST_DRIVE   = 2'd2,
        ST_TIMEOUT = 2'd3
`else
        ST_DRIVE   = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/manual_cmd_decode.sv
// -----------------------------------------------------------------------------
// manual_cmd_decode
// Combinational W/A/S/D decode into an 8-bit one-hot direction.
// Opposing keys cancel per axis (W+S, A+D). Any nonzero bit above the key
// nibble decodes to stop and raises o_err.
// Ports:
//   i_cmd  [CMD_W-1:0] command byte, key bits in [3:0]
//   o_dir  [7:0]       one-hot direction, 0 = stop
//   o_err              upper bits nonzero
// -----------------------------------------------------------------------------
module manual_cmd_decode
    import manual_drive_pkg::*;
#(
    parameter int CMD_W = 8
) (
    input  logic [CMD_W-1:0] i_cmd,
    output logic [DIR_W-1:0] o_dir,
    output logic             o_err
);

    logic w_upper;
    logic w_fwd;
    logic w_back;
    logic w_left;
    logic w_right;

    generate
        if (CMD_W > 4) begin : g_upper
            assign w_upper = |i_cmd[CMD_W-1:4];
        end else begin : g_no_upper
            assign w_upper = 1'b0;
        end
    endgenerate

    assign w_fwd   = i_cmd[KEY_W] & ~i_cmd[KEY_S];
    assign w_back  = i_cmd[KEY_S] & ~i_cmd[KEY_W];
    assign w_left  = i_cmd[KEY_A] & ~i_cmd[KEY_D];
    assign w_right = i_cmd[KEY_D] & ~i_cmd[KEY_A];

    always_comb begin
        o_dir = '0;
        o_err = w_upper;
        if (!w_upper) begin
            if (w_fwd) begin
                if (w_left)       o_dir[DIR_LF] = 1'b1;
                else if (w_right) o_dir[DIR_RF] = 1'b1;
                else              o_dir[DIR_F]  = 1'b1;
            end else if (w_back) begin
                if (w_left)       o_dir[DIR_LB] = 1'b1;
                else if (w_right) o_dir[DIR_RB] = 1'b1;
                else              o_dir[DIR_B]  = 1'b1;
            end else if (w_left) begin
                o_dir[DIR_L] = 1'b1;
            end else if (w_right) begin
                o_dir[DIR_R] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// -----------------------------------------------------------------------------
// manual_drive_ctrl
// Manual-drive command FSM: decodes framed W/A/S/D beats, debounces direction
// changes over HOLD_BEATS identical beats (stop is never debounced) and drives a
// registered one-hot direction plus stop.
// Optional feature macro: MANUAL_DRIVE_WATCHDOG_EN -- link watchdog that forces
// stop (state TIMEOUT) after TIMEOUT_CYCLES clocks without a command beat.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_manual_on        manual mode selected (level)
//   i_cmd_valid        one-cycle strobe qualifying i_cmd
//   i_cmd [CMD_W-1:0]  key bits [0]W [1]A [2]S [3]D, upper bits must be 0
//   o_dir [7:0]        one-hot direction F,B,L,R,LF,RF,LB,RB
//   o_stop             high exactly when o_dir == 0
//   o_cmd_err          one-cycle pulse after a processed beat with upper bits set
//   o_timeout          high while in TIMEOUT
//   o_dbg_state        current FSM state
// Handshake: i_cmd_valid is a strobe with no back-pressure; a beat is consumed
// in the cycle it is high, and only while in STOP or DRIVE is it decoded.
// -----------------------------------------------------------------------------
module manual_drive_ctrl
    import manual_drive_pkg::*;
#(
    parameter int CMD_W          = 8,
    parameter int HOLD_BEATS     = 2,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_manual_on,
    input  logic             i_cmd_valid,
    input  logic [CMD_W-1:0] i_cmd,
    output logic [DIR_W-1:0] o_dir,
    output logic             o_stop,
    output logic             o_cmd_err,
    output logic             o_timeout,
    output state_t           o_dbg_state
);

    localparam int HW = $clog2(HOLD_BEATS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_BEATS);

    generate
        if (CMD_W < 4 || HOLD_BEATS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("manual_drive_ctrl: illegal parameter value");
        end
    endgenerate

    state_t           r_state,  w_state_nx;
    logic [DIR_W-1:0] r_dir,    w_dir_nx;
    logic [DIR_W-1:0] r_cand,   w_cand_nx;
    logic [HW-1:0]    r_hold,   w_hold_nx;
    logic             r_stop;
    logic             r_cmd_err, w_err_nx;

    logic [DIR_W-1:0] w_dec_dir;
    logic             w_dec_err;
    logic [HW-1:0]    w_hold_new;

    manual_cmd_decode #(.CMD_W(CMD_W)) u_decode (
        .i_cmd (i_cmd),
        .o_dir (w_dec_dir),
        .o_err (w_dec_err)
    );

    // Count for this beat if it is a non-stop change: continue the candidate
    // run (saturating) or start a fresh run at 1.
    always_comb begin
        w_hold_new = HW'(1);
        if (w_dec_dir == r_cand) begin
            w_hold_new = (r_hold < HOLD_MAX) ? r_hold + HW'(1) : HOLD_MAX;
        end
    end

`ifdef MANUAL_DRIVE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] r_wd, w_wd_nx;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_cand_nx  = r_cand;
        w_hold_nx  = r_hold;
        w_err_nx   = 1'b0;
`ifdef MANUAL_DRIVE_WATCHDOG_EN
        w_wd_nx    = r_wd;
`endif
        if (!i_manual_on) begin
            // Leaving manual mode wins over any beat in the same cycle
            w_state_nx = ST_OFF;
            w_dir_nx   = '0;
            w_cand_nx  = '0;
            w_hold_nx  = '0;
`ifdef MANUAL_DRIVE_WATCHDOG_EN
            w_wd_nx    = '0;
`endif
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nx = ST_STOP;
                end
                ST_STOP, ST_DRIVE: begin
                    if (i_cmd_valid) begin
                        w_err_nx = w_dec_err;
`ifdef MANUAL_DRIVE_WATCHDOG_EN
                        w_wd_nx  = '0;
`endif
                        if (w_dec_dir == '0) begin
                            w_state_nx = ST_STOP;
                            w_dir_nx   = '0;
                            w_cand_nx  = '0;
                            w_hold_nx  = '0;
                        end else if (w_dec_dir == r_dir) begin
                            w_cand_nx = '0;
                            w_hold_nx = '0;
                        end else if (w_hold_new == HOLD_MAX) begin
                            w_state_nx = ST_DRIVE;
                            w_dir_nx   = w_dec_dir;
                            w_cand_nx  = '0;
                            w_hold_nx  = '0;
                        end else begin
                            w_cand_nx = w_dec_dir;
                            w_hold_nx = w_hold_new;
                        end
                    end
`ifdef MANUAL_DRIVE_WATCHDOG_EN
                    else if (r_wd == WD_LAST) begin
                        // This edge brings the idle count to the limit
                        w_state_nx = ST_TIMEOUT;
                        w_dir_nx   = '0;
                        w_cand_nx  = '0;
                        w_hold_nx  = '0;
                        w_wd_nx    = WD_MAX;
                    end else begin
                        w_wd_nx = r_wd + WD_W'(1);
                    end
`endif
                end
`ifdef MANUAL_DRIVE_WATCHDOG_EN
                ST_TIMEOUT: begin
                    // The waking beat only restores STOP; it is not decoded
                    if (i_cmd_valid) begin
                        w_state_nx = ST_STOP;
                        w_wd_nx    = '0;
                    end
                end
`endif
                default: begin
                    w_state_nx = ST_OFF;
                    w_dir_nx   = '0;
                    w_cand_nx  = '0;
                    w_hold_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_OFF;
            r_dir     <= '0;
            r_cand    <= '0;
            r_hold    <= '0;
            r_stop    <= 1'b1;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_dir     <= w_dir_nx;
            r_cand    <= w_cand_nx;
            r_hold    <= w_hold_nx;
            r_stop    <= (w_dir_nx == '0);
            r_cmd_err <= w_err_nx;
        end
    end

`ifdef MANUAL_DRIVE_WATCHDOG_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wd <= '0;
        end else begin
            r_wd <= w_wd_nx;
        end
    end
    assign o_timeout = (r_state == ST_TIMEOUT);
`else
    assign o_timeout = 1'b0;
`endif

    assign o_dir       = r_dir;
    assign o_stop      = r_stop;
    assign o_cmd_err   = r_cmd_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_manual_drive_ctrl
// Self-checking bench for manual_drive_ctrl (CMD_W=8, HOLD_BEATS=2,
// TIMEOUT_CYCLES=16). Expected output records are pushed to exp_q as each
// cycle's inputs are driven and popped/compared #1 after the following edge.
// Build with +define+MANUAL_DRIVE_WATCHDOG_EN to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_manual_drive_ctrl;
    import manual_drive_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       manual_on;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic [7:0] dir;
    logic       stop;
    logic       cmd_err;
    logic       timeout;
    state_t     dbg_state;

    always #5 clk = ~clk;

    manual_drive_ctrl #(
        .CMD_W          (8),
        .HOLD_BEATS     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_manual_on (manual_on),
        .i_cmd_valid (cmd_valid),
        .i_cmd       (cmd),
        .o_dir       (dir),
        .o_stop      (stop),
        .o_cmd_err   (cmd_err),
        .o_timeout   (timeout),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // record = {dir[7:0], stop, cmd_err, timeout}
    logic [10:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [10:0] ex(input logic [7:0] d, input logic e, input logic t);
        return {d, (d == 8'h00), e, t};
    endfunction

    task automatic check_out(input string name);
        logic [10:0] got;
        logic [10:0] want;
        got = {dir, stop, cmd_err, timeout};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got dir=%h stop=%b err=%b to=%b",
                     name, got[10:3], got[2], got[1], got[0]);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got dir=%h stop=%b err=%b to=%b, expected dir=%h stop=%b err=%b to=%b",
                         name, got[10:3], got[2], got[1], got[0],
                         want[10:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic check_state(input string name, input state_t want);
        checks++;
        if (dbg_state !== want) begin
            failures++;
            $display("FAIL %s: state got %0d expected %0d", name, dbg_state, want);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rn, input logic mo, input logic v,
                        input logic [7:0] c, input logic [10:0] exp, input string name);
        rst_n     = rn;
        manual_on = mo;
        cmd_valid = v;
        cmd       = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       mo;
        logic       v;
        logic [7:0] cmd;
        logic [7:0] d;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n     = 1'b0;
        manual_on = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 8'h00;

        //                 mo  v   cmd    exp dir e
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 1'b0}); // OFF -> STOP
        vecs.push_back('{1'b1, 1'b1, 8'h01, 8'h00, 1'b0}); // F candidate
        vecs.push_back('{1'b1, 1'b1, 8'h01, 8'h01, 1'b0}); // F accepted
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h01, 1'b0}); // R candidate
        vecs.push_back('{1'b1, 1'b1, 8'h02, 8'h01, 1'b0}); // L restarts candidate
        vecs.push_back('{1'b1, 1'b0, 8'h02, 8'h01, 1'b0}); // idle: counts beats only
        vecs.push_back('{1'b1, 1'b1, 8'h02, 8'h04, 1'b0}); // L accepted
        vecs.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 1'b0}); // stop, no debounce
        vecs.push_back('{1'b1, 1'b1, 8'h0A, 8'h00, 1'b0}); // A+D cancel -> stop
        vecs.push_back('{1'b1, 1'b1, 8'h31, 8'h00, 1'b1}); // upper bits -> err
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 1'b0}); // err lasts one cycle
        vecs.push_back('{1'b1, 1'b1, 8'h0B, 8'h00, 1'b0}); // W, A+D cancel
        vecs.push_back('{1'b1, 1'b1, 8'h0B, 8'h01, 1'b0}); // F
        vecs.push_back('{1'b1, 1'b1, 8'h05, 8'h00, 1'b0}); // W+S cancel -> stop
        vecs.push_back('{1'b1, 1'b1, 8'h09, 8'h00, 1'b0}); // RF candidate
        vecs.push_back('{1'b1, 1'b1, 8'h06, 8'h00, 1'b0}); // LB restarts
        vecs.push_back('{1'b1, 1'b1, 8'h06, 8'h40, 1'b0}); // LB accepted
        vecs.push_back('{1'b1, 1'b1, 8'h06, 8'h40, 1'b0}); // same dir holds
        vecs.push_back('{1'b1, 1'b1, 8'h0C, 8'h40, 1'b0}); // RB candidate
        vecs.push_back('{1'b1, 1'b1, 8'h0C, 8'h80, 1'b0}); // RB accepted
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'h80, 1'b0}); // B candidate
        vecs.push_back('{1'b1, 1'b0, 8'h04, 8'h80, 1'b0}); // idle
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'h02, 1'b0}); // B accepted
        vecs.push_back('{1'b0, 1'b1, 8'h04, 8'h00, 1'b0}); // manual_on drop wins
        vecs.push_back('{1'b0, 1'b1, 8'h31, 8'h00, 1'b0}); // OFF ignores err
        vecs.push_back('{1'b1, 1'b1, 8'h01, 8'h00, 1'b0}); // OFF->STOP, beat ignored
        vecs.push_back('{1'b1, 1'b1, 8'h01, 8'h00, 1'b0}); // F candidate (fresh)
        vecs.push_back('{1'b1, 1'b1, 8'h01, 8'h01, 1'b0}); // F accepted
        vecs.push_back('{1'b1, 1'b1, 8'h03, 8'h01, 1'b0}); // LF candidate
        vecs.push_back('{1'b1, 1'b1, 8'h03, 8'h10, 1'b0}); // LF accepted
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h10, 1'b0}); // R candidate
        vecs.push_back('{1'b1, 1'b1, 8'h00, 8'h00, 1'b0}); // stop clears candidate
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h00, 1'b0}); // R candidate again
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h08, 1'b0}); // R accepted

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(ex(8'h00, 1'b0, 1'b0));
        check_out("reset");
        check_state("reset_state", ST_OFF);

        // ---- table ----
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].mo, vecs[i].v, vecs[i].cmd,
                 ex(vecs[i].d, vecs[i].e, 1'b0), $sformatf("vec%0d", i));
        end
        check_state("drive_state", ST_DRIVE);

`ifdef MANUAL_DRIVE_WATCHDOG_EN
        // ---- watchdog: idle until timeout ----
        step(1'b1, 1'b1, 1'b1, 8'h01, ex(8'h08, 1'b0, 1'b0), "wd_f_cand");
        step(1'b1, 1'b1, 1'b1, 8'h01, ex(8'h01, 1'b0, 1'b0), "wd_f_acc");
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h01, 1'b0, 1'b0), $sformatf("wd_idle%0d", k));
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h00, 1'b0, 1'b1), "wd_timeout");
        check_state("wd_timeout_state", ST_TIMEOUT);
        step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h00, 1'b0, 1'b1), "wd_timeout_hold");
        step(1'b1, 1'b1, 1'b1, 8'h01, ex(8'h00, 1'b0, 1'b0), "wd_wake");
        check_state("wd_wake_state", ST_STOP);
        step(1'b1, 1'b1, 1'b1, 8'h01, ex(8'h00, 1'b0, 1'b0), "wd_re_cand");
        step(1'b1, 1'b1, 1'b1, 8'h01, ex(8'h01, 1'b0, 1'b0), "wd_re_acc");
        // limit reached in the same cycle as a beat: no timeout
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h01, 1'b0, 1'b0), $sformatf("wd_idle_b%0d", k));
        end
        step(1'b1, 1'b1, 1'b1, 8'h01, ex(8'h01, 1'b0, 1'b0), "wd_beat_at_limit");
        step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h01, 1'b0, 1'b0), "wd_after_limit_beat");
`else
        // ---- no watchdog: direction holds indefinitely ----
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h08, 1'b0, 1'b0), $sformatf("hold_idle%0d", k));
        end
`endif

        // ---- reset overrides an active beat ----
        step(1'b0, 1'b1, 1'b1, 8'h01, ex(8'h00, 1'b0, 1'b0), "reset_override");
        check_state("reset_override_state", ST_OFF);
        step(1'b1, 1'b1, 1'b0, 8'h00, ex(8'h00, 1'b0, 1'b0), "post_reset");
        check_state("post_reset_state", ST_STOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
